cpu_trap_unit: RTL and testbench

//   Datapath-side consumer of the IntCause/MRet control fields. Sits beside the

---
 rtl/cpu_trap_unit.sv | 214 +++++++++++++++++++++
 tb/tb_cpu_trap_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_trap_unit.sv
// cpu_trap_unit
//   Trap/return controller beside the execute stage. Accepts synchronous
//   exceptions (from int_cause_i), mret and a level-sensitive external
//   interrupt. It maintains mstatus (MIE/MPIE), mtvec, mepc and mcause, and
//   issues a one-cycle registered PC redirect plus pipeline flush. After the
//   redirect it ignores new events for DRAIN_CYCLES cycles. CSR writes are
//   still accepted during that window.
//
//   Optional feature: define TRAP_VECTORED_EN to make mtvec[0] (mode)
//   writable. In vectored mode, interrupts jump to base + 4*cause.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   valid_i         EX holds a live instruction
//   pc_i            PC of the EX instruction
//   int_cause_i     00 none, 01 illegal, 10 ecall, 11 ebreak
//   mret_i          EX instruction is mret
//   ext_irq_i       external interrupt request (level)
//   csr_we_i        CSR write strobe
//   csr_addr_i      CSR address (mstatus/mtvec/mepc/mcause)
//   csr_wdata_i     CSR write data
//   csr_rdata_o     combinational read of csr_addr_i (0 if unknown)
//   redirect_o      fetch loads redirect_pc_o this cycle
//   redirect_pc_o   redirect target
//   flush_o         kill IF/ID/EX (asserted together with redirect_o)
//   mie_o           mstatus.MIE
module cpu_trap_unit #(
    parameter int              XLEN         = 32,
    parameter int              DRAIN_CYCLES = 2,
    parameter logic [XLEN-1:0] RESET_MTVEC  = 'h0000_0008
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [1:0]      int_cause_i,
    input  logic            mret_i,
    input  logic            ext_irq_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            flush_o,
    output logic            mie_o
);

    localparam int CNT_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

    // Interrupt flag in the MSB, external machine interrupt code 11.
    localparam logic [XLEN-1:0] CAUSE_EXT_IRQ = {1'b1, {(XLEN-5){1'b0}}, 4'hB};

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  drain_cnt, drain_cnt_nxt;

    logic              mie, mpie;
    logic [XLEN-1:0]   mtvec, mepc, mcause;

    logic              take_trap, take_mret;
    logic [XLEN-1:0]   trap_cause;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   mtvec_base;
    logic [XLEN-1:0]   vec_off;
    logic              vec_hit;

    function automatic logic [XLEN-1:0] exc_code(input logic [1:0] cause);
        case (cause)
            2'b01:   return XLEN'(2);
            2'b10:   return XLEN'(11);
            2'b11:   return XLEN'(3);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Event arbitration happens only in RUN. Exceptions beat mret, and mret beats the interrupt.
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        take_trap     = 1'b0;
        take_mret     = 1'b0;
        trap_cause    = '0;
        case (state)
            RUN: begin
                if (valid_i) begin
                    if (int_cause_i != 2'b00) begin
                        take_trap  = 1'b1;
                        trap_cause = exc_code(int_cause_i);
                    end else if (mret_i) begin
                        take_mret  = 1'b1;
                    end else if (ext_irq_i && mie) begin
                        take_trap  = 1'b1;
                        trap_cause = CAUSE_EXT_IRQ;
                    end
                end
                if (take_trap || take_mret) state_nxt = FLUSH;
            end
            FLUSH: begin
                state_nxt     = DRAIN;
                drain_cnt_nxt = CNT_W'(DRAIN_CYCLES);
            end
            DRAIN: begin
                if (drain_cnt == CNT_W'(1)) begin
                    state_nxt     = RUN;
                    drain_cnt_nxt = '0;
                end else begin
                    drain_cnt_nxt = drain_cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt     = RUN;
                drain_cnt_nxt = '0;
            end
        endcase
    end

    // Redirect target. Vectored mode applies only to interrupts (cause MSB set).
    always_comb begin
        mtvec_base = {mtvec[XLEN-1:2], 2'b00};
        vec_off    = {trap_cause[XLEN-3:0], 2'b00};
`ifdef TRAP_VECTORED_EN
        vec_hit    = mtvec[0] && trap_cause[XLEN-1];
`else
        vec_hit    = 1'b0;
`endif
        if (take_mret)
            target = mepc;
        else if (vec_hit)
            target = mtvec_base + vec_off;
        else
            target = mtvec_base;
    end

    // The CSR write is applied first. A trap/mret in the same cycle then overrides
    // the fields it owns, because the later non-blocking assignment wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_o    <= 1'b0;
            flush_o       <= 1'b0;
            redirect_pc_o <= '0;
            mie           <= 1'b0;
            mpie          <= 1'b0;
            mepc          <= '0;
            mcause        <= '0;
            mtvec         <= RESET_MTVEC;
        end else begin
            redirect_o <= take_trap | take_mret;
            flush_o    <= take_trap | take_mret;
            if (take_trap || take_mret) redirect_pc_o <= target;

            if (csr_we_i) begin
                case (csr_addr_i)
                    ADDR_MSTATUS: begin
                        mie  <= csr_wdata_i[3];
                        mpie <= csr_wdata_i[7];
                    end
`ifdef TRAP_VECTORED_EN
                    ADDR_MTVEC:  mtvec <= {csr_wdata_i[XLEN-1:2], 1'b0, csr_wdata_i[0]};
`else
                    ADDR_MTVEC:  mtvec <= {csr_wdata_i[XLEN-1:2], 2'b00};
`endif
                    ADDR_MEPC:   mepc   <= {csr_wdata_i[XLEN-1:2], 2'b00};
                    ADDR_MCAUSE: mcause <= csr_wdata_i;
                    default: ;
                endcase
            end

            if (take_trap) begin
                mepc   <= pc_i & ~XLEN'(3);
                mcause <= trap_cause;
                mpie   <= mie;
                mie    <= 1'b0;
            end
            if (take_mret) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            ADDR_MSTATUS: begin
                csr_rdata_o[3] = mie;
                csr_rdata_o[7] = mpie;
            end
            ADDR_MTVEC:  csr_rdata_o = mtvec;
            ADDR_MEPC:   csr_rdata_o = mepc;
            ADDR_MCAUSE: csr_rdata_o = mcause;
            default:     csr_rdata_o = '0;
        endcase
    end

    assign mie_o = mie;

endmodule

// File: tb/tb_cpu_trap_unit.sv
// Bench for cpu_trap_unit.
// A cycle-level reference model tracks the architectural CSR state and a
// "blocked" countdown following each accepted event. The model and outputs
// are compared every clock. The CSR read path is compared every cycle.
// Literal checks pin the documented scenarios.
module tb_cpu_trap_unit;

    localparam int XLEN  = 32;
    localparam int DRAIN = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i;
    logic [XLEN-1:0]   pc_i;
    logic [1:0]        int_cause_i;
    logic              mret_i;
    logic              ext_irq_i;
    logic              csr_we_i;
    logic [11:0]       csr_addr_i;
    logic [XLEN-1:0]   csr_wdata_i;
    logic [XLEN-1:0]   csr_rdata_o;
    logic              redirect_o;
    logic [XLEN-1:0]   redirect_pc_o;
    logic              flush_o;
    logic              mie_o;

    always #5 clk = ~clk;

    cpu_trap_unit #(.XLEN(XLEN), .DRAIN_CYCLES(DRAIN), .RESET_MTVEC(32'h0000_0008)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i), .int_cause_i(int_cause_i),
        .mret_i(mret_i), .ext_irq_i(ext_irq_i), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o), .flush_o(flush_o), .mie_o(mie_o)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mepc, m_mcause;
    logic        m_redir;
    logic [31:0] m_rpc;
    logic        m_pc_known;
    int          m_block;   // edges still to ignore after an accepted event

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {24'h0, m_mpie, 3'b000, m_mie, 3'b000};
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    logic        o_mie, o_mpie, e_trap, e_mret;
    logic [31:0] o_mtvec, o_mepc, e_code, e_tgt;

    always @(posedge clk) begin
        if (rst) begin
            m_mie = 1'b0; m_mpie = 1'b0; m_mepc = 32'h0; m_mcause = 32'h0;
            m_mtvec = 32'h8; m_redir = 1'b0; m_rpc = 32'h0; m_block = 0;
            m_pc_known = 1'b1;
        end else begin
            o_mie = m_mie; o_mpie = m_mpie; o_mtvec = m_mtvec; o_mepc = m_mepc;
            e_trap = 1'b0; e_mret = 1'b0; e_code = 32'h0;
            if (m_block == 0 && valid_i) begin
                if (int_cause_i == 2'd1)      begin e_trap = 1'b1; e_code = 32'd2;  end
                else if (int_cause_i == 2'd2) begin e_trap = 1'b1; e_code = 32'd11; end
                else if (int_cause_i == 2'd3) begin e_trap = 1'b1; e_code = 32'd3;  end
                else if (mret_i)              e_mret = 1'b1;
                else if (ext_irq_i && o_mie)  begin e_trap = 1'b1; e_code = 32'h8000_000B; end
            end
            if (csr_we_i) begin
                case (csr_addr_i)
                    12'h300: begin m_mie = csr_wdata_i[3]; m_mpie = csr_wdata_i[7]; end
`ifdef TRAP_VECTORED_EN
                    12'h305: m_mtvec = csr_wdata_i & ~32'h2;
`else
                    12'h305: m_mtvec = csr_wdata_i & ~32'h3;
`endif
                    12'h341: m_mepc = csr_wdata_i & ~32'h3;
                    12'h342: m_mcause = csr_wdata_i;
                    default: ;
                endcase
            end
            m_redir = e_trap || e_mret;
            m_pc_known = m_redir;
            if (e_trap) begin
                m_mepc = pc_i & ~32'h3;
                m_mcause = e_code;
                m_mpie = o_mie;
                m_mie = 1'b0;
                e_tgt = o_mtvec & ~32'h3;
`ifdef TRAP_VECTORED_EN
                if (o_mtvec[0] && e_code[31]) e_tgt = e_tgt + ((e_code & 32'h7FFF_FFFF) << 2);
`endif
                m_rpc = e_tgt;
            end
            if (e_mret) begin
                m_rpc = o_mepc;
                m_mie = o_mpie;
                m_mpie = 1'b1;
            end
            if (m_redir) m_block = DRAIN + 1;
            else if (m_block > 0) m_block--;
        end
        #1;
        cmp("redirect_o", {31'h0, redirect_o}, {31'h0, m_redir});
        cmp("flush_o", {31'h0, flush_o}, {31'h0, m_redir});
        cmp("mie_o", {31'h0, mie_o}, {31'h0, m_mie});
        if (m_pc_known) cmp("redirect_pc_o", redirect_pc_o, m_rpc);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic r, input logic v, input logic [31:0] pc, input logic [1:0] ic,
                         input logic mr, input logic irq, input logic we, input logic [11:0] a,
                         input logic [31:0] wd);
        @(negedge clk);
        rst = r; valid_i = v; pc_i = pc; int_cause_i = ic; mret_i = mr; ext_irq_i = irq;
        csr_we_i = we; csr_addr_i = a; csr_wdata_i = wd;
        #1;
        cmp("csr_rdata", csr_rdata_o, m_read(csr_addr_i));
    endtask

    task automatic idle(input int n, input logic [11:0] a);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 2'd0, 0, 0, 0, a, 0);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        drive(0, 0, 0, 2'd0, 0, 0, 1, a, d);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    logic [31:0] exp_irq_pc;
    logic [3:0]  hold_exp;

    initial begin
        rst = 1; valid_i = 0; pc_i = 0; int_cause_i = 0; mret_i = 0; ext_irq_i = 0;
        csr_we_i = 0; csr_addr_i = 12'h300; csr_wdata_i = 0;

        // reset state
        drive(1, 0, 0, 2'd0, 0, 0, 0, 12'h300, 0);
        drive(1, 0, 0, 2'd0, 0, 0, 0, 12'h300, 0);
        after_edge();
        cmp("rst_redirect", {31'h0, redirect_o}, 32'h0);
        cmp("rst_flush", {31'h0, flush_o}, 32'h0);
        cmp("rst_pc", redirect_pc_o, 32'h0);
        cmp("rst_mie", {31'h0, mie_o}, 32'h0);
        idle(1, 12'h305);
        cmp("rst_mtvec", csr_rdata_o, 32'h8);

        // ecall at 0x100 with mtvec 0x200, MIE previously 1
        csr_wr(12'h305, 32'h200);
        csr_wr(12'h300, 32'h8);
        drive(0, 1, 32'h100, 2'd2, 0, 0, 0, 12'h300, 0);
        after_edge();
        cmp("ecall_redirect", {31'h0, redirect_o}, 32'h1);
        cmp("ecall_pc", redirect_pc_o, 32'h200);
        cmp("ecall_mie", {31'h0, mie_o}, 32'h0);
        idle(1, 12'h341);
        cmp("ecall_mepc", csr_rdata_o, 32'h100);
        after_edge();
        cmp("ecall_redirect_drop", {31'h0, redirect_o}, 32'h0);
        idle(1, 12'h342);
        cmp("ecall_mcause", csr_rdata_o, 32'd11);
        idle(1, 12'h300);
        cmp("ecall_mstatus", csr_rdata_o, 32'h80);
        idle(2, 12'h300);

        // mret to 0x104
        csr_wr(12'h341, 32'h104);
        drive(0, 1, 32'h500, 2'd0, 1, 0, 0, 12'h300, 0);
        after_edge();
        cmp("mret_pc", redirect_pc_o, 32'h104);
        cmp("mret_mie", {31'h0, mie_o}, 32'h1);
        idle(1, 12'h300);
        cmp("mret_mstatus", csr_rdata_o, 32'h88);
        idle(3, 12'h300);

        // external interrupt at 0x40, mtvec 0x201
        csr_wr(12'h305, 32'h201);
`ifdef TRAP_VECTORED_EN
        exp_irq_pc = 32'h22C;
`else
        exp_irq_pc = 32'h200;
`endif
        drive(0, 1, 32'h40, 2'd0, 0, 1, 0, 12'h300, 0);
        after_edge();
        cmp("irq_pc", redirect_pc_o, exp_irq_pc);
        // irq held through drain, MIE re-enabled in FLUSH cycle: taken on 3rd cycle after FLUSH
        hold_exp = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 32'h40, 2'd0, 0, 1, (i == 0), 12'h300, 32'h8);
            after_edge();
            cmp("drain_hold", {31'h0, redirect_o}, {31'h0, hold_exp[i]});
        end
        idle(1, 12'h342);
        cmp("irq_mcause", csr_rdata_o, 32'h8000_000B);
        idle(1, 12'h341);
        cmp("irq_mepc", csr_rdata_o, 32'h40);

        // irq with MIE=0 never taken
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 32'h44, 2'd0, 0, 1, 0, 12'h300, 0);
            after_edge();
            cmp("irq_masked", {31'h0, redirect_o}, 32'h0);
        end

        // illegal + mret + irq together -> illegal wins
        csr_wr(12'h300, 32'h8);
        drive(0, 1, 32'h80, 2'd1, 1, 1, 0, 12'h300, 0);
        after_edge();
        cmp("prio_pc", redirect_pc_o, 32'h200);
        idle(3, 12'h300);
        idle(1, 12'h342);
        cmp("prio_mcause", csr_rdata_o, 32'd2);

        csr_wr(12'h341, 32'h333);
        idle(1, 12'h341);
        cmp("mepc_mask", csr_rdata_o, 32'h330);

        // reset while draining
        drive(0, 1, 32'h10, 2'd2, 0, 0, 0, 12'h300, 0);
        drive(0, 0, 0, 2'd0, 0, 0, 1, 12'h300, 32'h8);
        drive(1, 0, 0, 2'd0, 0, 0, 0, 12'h300, 0);
        after_edge();
        cmp("rst_drain_redirect", {31'h0, redirect_o}, 32'h0);
        cmp("rst_drain_pc", redirect_pc_o, 32'h0);
        cmp("rst_drain_mie", {31'h0, mie_o}, 32'h0);
        drive(0, 1, 32'h20, 2'd3, 0, 0, 0, 12'h342, 0);
        after_edge();
        cmp("post_rst_take", {31'h0, redirect_o}, 32'h1);
        cmp("post_rst_pc", redirect_pc_o, 32'h8);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] a;
            case ($urandom_range(0, 4))
                0: a = 12'h300;
                1: a = 12'h305;
                2: a = 12'h341;
                3: a = 12'h342;
                default: a = 12'($urandom);
            endcase
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), $urandom,
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                  ($urandom_range(0, 7) == 0), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0), a, $urandom);
        end
        idle(2, 12'h300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
